// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types and segment table for the seven-segment scan controller
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sseg_hex_decoder.sv
// rtl/sseg_hex_decoder.sv - combinational hex nibble to active-low segment pattern
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - 8-digit seven-segment scan controller with tear-free frame commit
// Optional leading-zero blanking enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic [31:0]           value_i,
    input  logic                  load_i,
    input  logic [NUM_DIGITS-1:0] dp_mask_i,
    output logic [NUM_DIGITS-1:0] an_n_o,
    output logic [6:0]            seg_n_o,
    output logic                  dp_n_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    frame_q, frame_d;
    logic                    pending_q, pending_d;
    logic [31:0]             pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [31:0]             shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic [DW+1:0]           shamt;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg_n;
    logic                    lzb_blank;

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q;
        frame_d      = 1'b0;
        pending_d    = pending_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = GUARD;
                    digit_d = '0;
                    cnt_d   = '0;
                    frame_d = 1'b1;
                end
            end
            GUARD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = GUARD;
                    if (digit_q == DIGIT_LAST) begin
                        digit_d = '0;
                        frame_d = 1'b1;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit happens in the cycle frame_o is high, i.e. while digit 0 is still guarded
        if (frame_q && pending_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
            pending_d    = 1'b0;
        end

        // A coincident load lands after the commit took the old contents
        if (load_i) begin
            pend_val_d = value_i;
            pend_dp_d  = dp_mask_i;
            pending_d  = 1'b1;
        end

        if (!enable_i) begin
            state_d = IDLE;
            digit_d = '0;
            cnt_d   = '0;
            frame_d = 1'b0;
        end
    end

    assign shamt  = {digit_d, 2'b00};
    assign nibble = 4'(shadow_val_d >> shamt);

    sseg_hex_decoder u_dec (
        .nibble_i (nibble),
        .seg_n_o  (dec_seg_n)
    );

`ifdef SSEG_LZB_EN
    localparam logic [31:0] VAL_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);
    assign lzb_blank = (digit_d != '0) && !shadow_dp_d[digit_d]
                     && (((shadow_val_d & VAL_MASK) >> shamt) == 32'd0);
`else
    assign lzb_blank = 1'b0;
`endif

    // Pins are registered from next-state so they line up with the state register
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == DRIVE) begin
            an_d = ~(NUM_DIGITS'(1) << digit_d);
            if (!lzb_blank) begin
                seg_d = dec_seg_n;
                dp_d  = ~shadow_dp_d[digit_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            digit_q      <= '0;
            cnt_q        <= '0;
            frame_q      <= 1'b0;
            pending_q    <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            pending_q    <= pending_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an_n_o    = an_q;
    assign seg_n_o   = seg_q;
    assign dp_n_o    = dp_q;
    assign frame_o   = frame_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable_i;
    logic [31:0] value_i;
    logic        load_i;
    logic [7:0]  dp_mask_i;
    logic [7:0]  an_n_o;
    logic [6:0]  seg_n_o;
    logic        dp_n_o;
    logic        frame_o;
    logic        pending_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS   (8),
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable_i  (enable_i),
        .value_i   (value_i),
        .load_i    (load_i),
        .dp_mask_i (dp_mask_i),
        .an_n_o    (an_n_o),
        .seg_n_o   (seg_n_o),
        .dp_n_o    (dp_n_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_o !== 1'b1 && n < 200);
        chk("frame_seen", {31'd0, frame_o}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] m);
        value_i   = v;
        dp_mask_i = m;
        load_i    = 1'b1;
        @(negedge clk);
        load_i    = 1'b0;
    endtask

    task automatic chk_pins(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
        chk({tag, "_an"}, {24'd0, an_n_o}, {24'd0, an});
        chk({tag, "_seg"}, {25'd0, seg_n_o}, {25'd0, seg});
        chk({tag, "_dp"}, {31'd0, dp_n_o}, {31'd0, dp});
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        enable_i  = 1'b0;
        value_i   = 32'd0;
        load_i    = 1'b0;
        dp_mask_i = 8'd0;
        step(3);
        chk_pins("reset", 8'hFF, 7'h7F, 1'b1);
        chk("reset_frame", {31'd0, frame_o}, 32'd0);
        chk("reset_pending", {31'd0, pending_o}, 32'd0);

        reset_n = 1'b1;
        step(1);
        enable_i = 1'b1;
        step(1);
        chk("first_frame", {31'd0, frame_o}, 32'd1);
        chk("first_guard_an", {24'd0, an_n_o}, 32'hFF);
        step(1);
        chk("frame_one_cycle", {31'd0, frame_o}, 32'd0);
        chk("guard2_an", {24'd0, an_n_o}, 32'hFF);
        step(1);
        chk_pins("d0_first", 8'hFE, 7'h40, 1'b1);
        step(5);
        chk_pins("d0_last", 8'hFE, 7'h40, 1'b1);
        step(1);
        chk_pins("d1_guard", 8'hFF, 7'h7F, 1'b1);
        step(2);
        chk_pins("d1", 8'hFD, 7'h40, 1'b1);
        for (int k = 2; k < 8; k++) begin
            step(8);
            chk("walk_an", {24'd0, an_n_o}, {24'd0, ~(8'd1 << k)});
        end
        wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_o !== 1'b1 && n < 200);
        chk("frame_period", n, 64);

        step(20);
        do_load(32'h89AB_CDEF, 8'h01);
        chk("pending_set", {31'd0, pending_o}, 32'd1);
        wait_frame();
        chk("pending_at_commit", {31'd0, pending_o}, 32'd1);
        step(1);
        chk("pending_cleared", {31'd0, pending_o}, 32'd0);
        step(1);
        chk_pins("hex_d0", 8'hFE, 7'h0E, 1'b0);
        step(8);
        chk_pins("hex_d1", 8'hFD, 7'h06, 1'b1);
        step(48);
        chk_pins("hex_d7", 8'h7F, 7'h00, 1'b1);

        wait_frame();
        step(5);
        do_load(32'h1111_1111, 8'h00);
        step(3);
        do_load(32'h2222_2222, 8'h00);
        wait_frame();
        step(2);
        chk_pins("latest_d0", 8'hFE, 7'h24, 1'b1);
        step(8);
        chk_pins("latest_d1", 8'hFD, 7'h24, 1'b1);

        do_load(32'h3333_3333, 8'h00);
        wait_frame();
        do_load(32'h4444_4444, 8'h00);
        chk("coincide_pending", {31'd0, pending_o}, 32'd1);
        step(1);
        chk("coincide_old_seg", {25'd0, seg_n_o}, 32'h30);
        wait_frame();
        chk("coincide_pending2", {31'd0, pending_o}, 32'd1);
        step(1);
        chk("coincide_pending_clr", {31'd0, pending_o}, 32'd0);
        step(1);
        chk("coincide_new_seg", {25'd0, seg_n_o}, 32'h19);

        wait_frame();
        step(27);
        chk("pre_disable_an", {24'd0, an_n_o}, 32'hF7);
        enable_i = 1'b0;
        step(1);
        chk_pins("disabled", 8'hFF, 7'h7F, 1'b1);
        chk("disabled_frame", {31'd0, frame_o}, 32'd0);
        step(3);
        chk("disabled_hold_an", {24'd0, an_n_o}, 32'hFF);
        enable_i = 1'b1;
        step(1);
        chk("reenable_frame", {31'd0, frame_o}, 32'd1);
        step(2);
        chk_pins("reenable_d0", 8'hFE, 7'h19, 1'b1);

        do_load(32'h0000_0105, 8'h00);
        wait_frame();
        step(2);
        chk_pins("lz_d0", 8'hFE, 7'h12, 1'b1);
        step(8);
        chk_pins("lz_d1", 8'hFD, 7'h40, 1'b1);
        step(8);
        chk_pins("lz_d2", 8'hFB, 7'h79, 1'b1);
        step(8);
`ifdef SSEG_LZB_EN
        chk_pins("lz_d3", 8'hF7, 7'h7F, 1'b1);
`else
        chk_pins("lz_d3", 8'hF7, 7'h40, 1'b1);
`endif
        do_load(32'h0000_0105, 8'h80);
        wait_frame();
        step(58);
        chk_pins("lz_dp_d7", 8'h7F, 7'h40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display fed by the 32-bit sseg PIO output word.
- Captures the PIO word (8 hex nibbles) into a pending register.
- Commits it to a shadow register only at a frame boundary, so no digit tearing occurs.
- Scans the digits one at a time with an anti-ghosting guard interval.
- Sits between the PIO out_port and the board anode/segment pins.

Parameters:
NUM_DIGITS, 8, digits scanned; digit k shows nibble value[4k+3:4k]; legal range 1..8.
PRESCALE, 50000, clk cycles per digit slot (guard + drive); must be > BLANK_CYCLES.
BLANK_CYCLES, 500, guard cycles per slot with all anodes off; must be >= 1.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  scan enable; low forces display dark
value_i  in  32  display word (connect to PIO out_port)
load_i  in  1  single-cycle strobe: capture value_i and dp_mask_i into pending
dp_mask_i  in  NUM_DIGITS  decimal-point enable per digit, active-high
an_n_o  out  NUM_DIGITS  anode select, one-hot active-low
seg_n_o  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n_o  out  1  decimal point, active-low
frame_o  out  1  one-cycle pulse at each frame commit (digit 0 guard entry)
pending_o  out  1  high while a captured value awaits commit

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All outputs registered.
- Reset values:
  - an_n_o all 1; seg_n_o 7'h7F; dp_n_o 1; frame_o 0; pending_o 0.
  - shadow and pending value/dp registers 0; state IDLE; digit index 0; slot counter 0.
- States: IDLE, GUARD, DRIVE.
- IDLE:
  - Anodes off, segments off.
  - When enable_i is sampled 1: go to GUARD, digit 0, counter 0, perform frame commit.
- GUARD:
  - Anodes all 1, seg_n_o 7'h7F.
  - Counter increments each cycle; at counter == BLANK_CYCLES-1 go to DRIVE.
- DRIVE:
  - an_n_o[digit] = 0, all other anodes 1.
  - seg_n_o = decode(shadow nibble[digit]); dp_n_o = ~shadow_dp[digit].
  - At counter == PRESCALE-1: counter 0, go to GUARD with digit+1.
  - Digit index wraps NUM_DIGITS-1 -> 0; the wrap triggers a frame commit.
- Frame commit:
  - If pending_o=1: shadow <= pending, pending_o <= 0.
  - frame_o pulses in the commit cycle whether or not a new value was applied.
- load_i:
  - Sets pending_o=1 and overwrites the pending registers; the latest load wins, with no queueing.
  - If load_i coincides with a commit, the commit uses the old pending contents. The new load stays pending and pending_o remains 1.
- enable_i deasserted in any state: next cycle IDLE, outputs dark, digit 0, counter 0. Pending and shadow are preserved.
- Counter width: $clog2(PRESCALE). Frame period: NUM_DIGITS*PRESCALE cycles.
- Decode table, active-low, for values 0..F:
  40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E

Optional Feature:
Macro SSEG_LZB_EN enables leading-zero blanking.
- With the macro: in DRIVE, a digit is blanked (seg_n_o=7'h7F, dp_n_o=1) when it is nonzero-indexed, its nibble is 0, and all higher-indexed nibbles within NUM_DIGITS are 0. Digit 0 is never blanked.
- A digit whose dp_mask bit is set is never blanked.
- The anode is still driven for a blanked digit, so scan timing is unchanged.
- Without the macro: all digits always display their nibble.

Decomposition:
- Package sseg_pkg holds:
  - the state enum (IDLE/GUARD/DRIVE);
  - the 16-entry active-low segment constant table;
  - SEG_OFF = 7'h7F.
- One sub-module: sseg_hex_decoder. Combinational nibble -> seg_n using the package table; instantiated once on the muxed nibble.

Test Plan:
(Parameters for all scenarios: PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=8.)
- Reset then enable_i=1 with no load: frame_o pulse; digit 0 shows 7'h40 for 6 cycles after 2 dark cycles; an_n_o walks FE,FD,...,7F; frame repeats every 64 cycles.
- load_i with value 32'h89ABCDEF, dp_mask 8'h01 mid-frame: pending_o=1 until next frame_o. Then digit0 shows 0E with dp_n_o=0, digit7 shows 00.
- Two loads in one frame (32'h11111111 then 32'h22222222): only 2 (7'h24) is displayed after the commit.
- load_i in the same cycle as frame_o: the old pending value is committed; pending_o stays 1; the new value appears at the following frame.
- enable_i dropped during DRIVE of digit 3: next cycle an_n_o=FF and seg_n_o=7F. Re-enable restarts at digit 0 with frame_o.
- SSEG_LZB_EN with value 32'h00000105: digits 3..7 blanked (seg 7F, anode active); digit 1 shows 40; digit 2 shows 79; digit 0 shows 12.
